// File: rtl/sdcapdma_pkg.sv
// sdcapdma shared definitions: geometry defaults,
// burst length and the two FSM state encodings.
package sdcapdma_pkg;

  localparam int WIDTH_DEF  = 720;
  localparam int HEIGHT_DEF = 240;
  localparam int BURSTLEN   = 4;

  typedef enum logic [1:0] {
    CAP_SYNC,
    CAP_RUN,
    CAP_FLUSH
  } cap_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_DATA
  } mem_t;

endpackage

// File: rtl/sdcapdma_fifo.sv
// sdcapfifo: single-clock first-word-fall-through FIFO.
// Ports: push/din, pop/dout (head), flush, count, full, empty.
module sdcapfifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         dopush;
  logic         dopop;

  assign dopop  = pop && !empty;
  // a pop in the same cycle frees the slot, so push is legal when full
  assign dopush = push && (!full || dopop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (dopush) wp <= wp + 1'b1;
      if (dopop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dopush) mem[wp[AW-1:0]] <= din;
  end

  assign count = wp - rp;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];

endmodule

// File: rtl/sdcapdma.sv
// sdcapdma: capture-side write DMA, SD pixel stream -> framebuffer.
// Ports: pix* stream in, mem* 4-word write bursts, fielddone, err.
import sdcapdma_pkg::*;

module sdcapdma #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int BASE   = 0,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixd,
  input  logic        pixvalid,
  input  logic        pixsof,
  output logic [22:0] memaddr,
  output logic [1:0]  memlen,
  input  logic [31:0] memrdata,
  output logic [31:0] memwdata,
  output logic        memreq,
  output logic        memwr,
  input  logic        memack,
  input  logic        memready,
  output logic        fielddone,
  output logic        err
);

  localparam int          NPIX   = WIDTH * HEIGHT;
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [17:0] NPIX18 = 18'(NPIX);
  localparam logic [22:0] BASE23 = 23'(BASE);
  localparam logic [22:0] LAST23 = 23'(BASE + NPIX - BURSTLEN);
  localparam logic [CW-1:0] BL   = CW'(BURSTLEN);

  cap_t          cst;
  mem_t          mst;
  logic [17:0]   pixcnt;
  logic [1:0]    beat;
  logic          push;
  logic          pop;
  logic          flush;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [23:0]   head;
  logic          pend;
  logic          bad;
  logic          unused_rdata;

  assign unused_rdata = ^{memrdata, empty};

  // field complete: only a sof may follow
  assign pend  = (pixcnt == NPIX18);
  // sof must coincide exactly with a complete field
  assign bad   = (cst == CAP_RUN) && pixvalid &&
                 ((pixsof != pend) || (full && !pop));
  assign push  = pixvalid && !bad &&
                 ((cst == CAP_SYNC && pixsof) || cst == CAP_RUN);
  assign pop   = (mst == MEM_DATA) && memack;
  assign flush = (cst == CAP_FLUSH) && (mst == MEM_IDLE);

  sdcapfifo #(.DEPTH(DEPTH), .W(24)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (pixd),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign memwdata = {8'h00, head};
  assign memlen   = 2'd3;
  assign memwr    = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cst       <= CAP_SYNC;
      mst       <= MEM_IDLE;
      pixcnt    <= '0;
      beat      <= '0;
      memreq    <= 1'b0;
      memaddr   <= BASE23;
      fielddone <= 1'b0;
      err       <= 1'b0;
    end else begin
      fielddone <= 1'b0;

      unique case (1'b1)
        (cst == CAP_SYNC): begin
          if (pixvalid && pixsof) begin
            cst    <= CAP_RUN;
            pixcnt <= 18'd1;
          end
        end
        (cst == CAP_RUN): begin
          if (bad) begin
            err <= 1'b1;
            cst <= CAP_FLUSH;
          end else if (pixvalid) begin
            pixcnt <= pend ? 18'd1 : pixcnt + 18'd1;
          end
        end
        (cst == CAP_FLUSH): begin
          if (mst == MEM_IDLE) begin
            cst    <= CAP_SYNC;
            pixcnt <= '0;
          end
        end
        default: cst <= CAP_SYNC;
      endcase

      unique case (1'b1)
        (mst == MEM_IDLE): begin
          if (cst != CAP_FLUSH && count >= BL) begin
            memreq <= 1'b1;
            mst    <= MEM_REQ;
          end else if (flush) begin
            memaddr <= BASE23;
          end
        end
        (mst == MEM_REQ): begin
          if (memready) begin
            memreq <= 1'b0;
            beat   <= '0;
            mst    <= MEM_DATA;
          end
        end
        (mst == MEM_DATA): begin
          if (memack) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              mst <= MEM_IDLE;
              if (memaddr == LAST23) begin
                memaddr   <= BASE23;
                fielddone <= 1'b1;
              end else begin
                memaddr <= memaddr + 23'd4;
              end
            end
          end
        end
        default: mst <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcapdma.sv
// tb_sdcapdma: table vectors, directed corner sequences and a
// randomized run, all checked against a pixel-level scoreboard.
module tb_sdcapdma;

  localparam int W    = 16;
  localparam int H    = 4;
  localparam int N    = W * H;
  localparam int BASE = 0;

  logic        clk = 0;
  logic        rst = 1;
  logic [23:0] pixd = '0;
  logic        pixvalid = 0;
  logic        pixsof = 0;
  logic [22:0] memaddr;
  logic [1:0]  memlen;
  logic [31:0] memrdata = '0;
  logic [31:0] memwdata;
  logic        memreq;
  logic        memwr;
  logic        memack = 0;
  logic        memready = 0;
  logic        fielddone;
  logic        err;

  always #5 clk = ~clk;

  sdcapdma #(.WIDTH(W), .HEIGHT(H), .BASE(BASE), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pixd      (pixd),
    .pixvalid  (pixvalid),
    .pixsof    (pixsof),
    .memaddr   (memaddr),
    .memlen    (memlen),
    .memrdata  (memrdata),
    .memwdata  (memwdata),
    .memreq    (memreq),
    .memwr     (memwr),
    .memack    (memack),
    .memready  (memready),
    .fielddone (fielddone),
    .err       (err)
  );

  typedef struct {
    int          addr;
    logic [23:0] data;
  } ent_t;

  typedef struct {
    int pre;
    int n;
    int tail;
    int exp_words;
    bit exp_err;
    int exp_done;
  } vec_t;

  ent_t expq[$];
  int   nchk = 0;
  int   nfail = 0;
  int   beats = 0;
  int   acked = 0;
  int   words = 0;
  int   dones = 0;
  int   baddr = 0;
  bit   rnd = 0;
  bit   ack_lim = 0;
  bit   hold_rdy = 0;
  bit   alow = 0;
  bit   rlow = 0;
  bit   mrun = 0;
  int   mcnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // memory controller model: acts just after each rising edge
  initial begin : resp
    bit   ok;
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      memack   = 0;
      memready = 0;
      if (rst) begin
        beats = 0;
        acked = 0;
        continue;
      end
      if (fielddone) dones++;
      if (beats > 0) begin
        ok = 1;
        if (rnd && !alow && $urandom_range(1, 0) == 0) ok = 0;
        if (ack_lim && acked >= 2) ok = 0;
        alow = !ok;
        if (ok) begin
          memack = 1;
          if (expq.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL wr_unexpected: data %0h, required no write",
                     memwdata);
          end else begin
            e = expq.pop_front();
            chk("wr_addr", 32'(baddr + 4 - beats), 32'(e.addr));
            chk("wr_data", memwdata, {8'h00, e.data});
          end
          beats--;
          acked++;
          words++;
        end
      end else if (memreq) begin
        ok = !hold_rdy;
        if (rnd && !rlow && $urandom_range(1, 0) == 0) ok = 0;
        rlow = !ok;
        memready = ok;
        if (ok) begin
          baddr = int'(memaddr);
          beats = 4;
          acked = 0;
        end
      end
    end
  end

  // reference: which pixels land where, from the field rules alone
  task automatic model(bit sof, logic [23:0] d);
    if (!mrun) begin
      if (sof) begin
        mrun = 1;
        mcnt = 1;
        expq.push_back('{BASE, d});
      end
    end else if (sof && mcnt == N) begin
      mcnt = 1;
      expq.push_back('{BASE, d});
    end else if (sof || mcnt == N) begin
      mrun = 0;
      repeat (mcnt % 4) void'(expq.pop_back());
    end else begin
      expq.push_back('{BASE + mcnt, d});
      mcnt++;
    end
  endtask

  task automatic drive(bit sof, logic [23:0] d, int gap);
    pixvalid = 1;
    pixsof   = sof;
    pixd     = d;
    @(negedge clk);
    pixvalid = 0;
    pixsof   = 0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send(bit sof, logic [23:0] d, int gap);
    model(sof, d);
    drive(sof, d, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1;
    pixvalid = 0;
    pixsof   = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_memreq", 32'(memreq), 0);
    chk("rst_memaddr", 32'(memaddr), BASE);
    chk("rst_err", 32'(err), 0);
    chk("rst_fielddone", 32'(fielddone), 0);
    chk("rst_memlen", 32'(memlen), 3);
    chk("rst_memwr", 32'(memwr), 1);
    expq.delete();
    mrun  = 0;
    mcnt  = 0;
    words = 0;
    dones = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || beats != 0) && t < 600) begin
      @(negedge clk);
      t++;
    end
    nchk++;
    if (t >= 600) begin
      nfail++;
      $display("FAIL drain_timeout: %0d words pending, required 0",
               expq.size());
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[7];
    int   t;
    logic [23:0] d;

    tbl[0] = '{0, 8, 0, 8, 0, 0};
    tbl[1] = '{5, 0, 0, 0, 0, 0};
    tbl[2] = '{0, N, 1, N + 4, 0, 1};
    tbl[3] = '{0, 10, 3, 12, 1, 0};
    tbl[4] = '{0, N, 2, N, 1, 1};
    tbl[5] = '{3, 12, 0, 12, 0, 0};
    tbl[6] = '{0, 6, 3, 8, 1, 0};

    repeat (2) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      do_reset();
      for (int i = 0; i < tbl[k].pre; i++)
        send(0, 24'hEE0000 | 24'(i), 3);
      for (int i = 0; i < tbl[k].n; i++)
        send(i == 0, {8'(k), 16'(i + 1)}, 3);
      if (tbl[k].tail == 1 || tbl[k].tail == 3) begin
        send(1, {8'(k), 16'h8000}, 3);
        if (tbl[k].tail == 3) repeat (30) @(negedge clk);
        if (tbl[k].tail == 3) send(1, {8'(k), 16'h9000}, 3);
        for (int i = 1; i < 4; i++)
          send(0, {8'(k), 16'h9000 | 16'(i)}, 3);
      end
      if (tbl[k].tail == 2) send(0, {8'(k), 16'h7000}, 3);
      drain();
      chk($sformatf("v%0d_words", k), 32'(words), 32'(tbl[k].exp_words));
      chk($sformatf("v%0d_err", k), 32'(err), 32'(tbl[k].exp_err));
      chk($sformatf("v%0d_done", k), 32'(dones), 32'(tbl[k].exp_done));
      chk($sformatf("v%0d_memreq", k), 32'(memreq), 0);
    end

    // randomized pacing and memory backpressure over three fields
    do_reset();
    rnd = 1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++)
        send(i == 0, 24'($urandom), $urandom_range(5, 3));
    drain();
    rnd = 0;
    chk("rnd_words", 32'(words), 32'(3 * N));
    chk("rnd_done", 32'(dones), 3);
    chk("rnd_err", 32'(err), 0);
    chk("rnd_memaddr", 32'(memaddr), BASE);

    // FIFO overflow while the first request is stalled
    do_reset();
    hold_rdy = 1;
    for (int i = 0; i < 4; i++) expq.push_back('{BASE + i, 24'(i + 1)});
    for (int i = 0; i < 40; i++) drive(i == 0, 24'(i + 1), 1);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_memreq_held", 32'(memreq), 1);
    hold_rdy = 0;
    drain();
    chk("ovf_words", 32'(words), 4);
    chk("ovf_memaddr", 32'(memaddr), BASE);
    chk("ovf_memreq", 32'(memreq), 0);
    for (int i = 0; i < 4; i++) send(i == 0, 24'h330000 | 24'(i), 3);
    drain();
    chk("ovf_resync_words", 32'(words), 8);
    chk("ovf_err_sticky", 32'(err), 1);

    // reset in the middle of a burst, after two acks
    do_reset();
    ack_lim = 1;
    for (int i = 0; i < 4; i++) send(i == 0, 24'hA00000 | 24'(i), 1);
    t = 0;
    while (acked < 2 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("mid_acks", 32'(acked), 2);
    ack_lim = 0;
    do_reset();
    for (int i = 0; i < 4; i++) send(i == 0, 24'hB00000 | 24'(i), 3);
    drain();
    chk("mid_words", 32'(words), 4);
    chk("mid_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
